// File: rtl/arb_pkg.sv
// arb_pkg: shared types for the memory-port arbiter (FSM states, owner encoding, guard counter width).
package arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;
    function automatic int starve_cnt_w(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction
endpackage

// File: rtl/starve_guard.sv
// starve_guard: counts CPU grants made while DMA waits and forces a DMA grant at STARVE_MAX.
// Only instantiated when DMA_STARVE_GUARD_EN is defined.
module starve_guard
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_i,
    input  logic dma_req_i,
    input  logic grant_dma_i,
    output logic force_dma_o
);
    localparam int CW = starve_cnt_w(STARVE_MAX);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = !arb_i ? cnt_q : (!dma_req_i || grant_dma_i) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign force_dma_o = cnt_q >= CW'(STARVE_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the CPU MEM stage and the DMA loader.
// Define DMA_STARVE_GUARD_EN to let DMA win after STARVE_MAX consecutive CPU grants.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              pipe_stall,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic [LW-1:0] lat_q, lat_d;
    logic wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic arb, grant_dma, force_dma;
`ifdef DMA_STARVE_GUARD_EN
    starve_guard #(.STARVE_MAX(STARVE_MAX)) u_guard (
        .clk(clk), .reset(reset), .arb_i(arb), .dma_req_i(dma_req),
        .grant_dma_i(grant_dma), .force_dma_o(force_dma)
    );
`else
    // fixed CPU priority; the parameter stays in the interface for guarded builds
    localparam int unused_starve_max = STARVE_MAX;
    assign force_dma = 1'b0;
`endif
    assign arb       = state_q == IDLE && (cpu_req || dma_req);
    assign grant_dma = dma_req && (!cpu_req || force_dma);
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: if (arb) begin
                owner_d = grant_dma ? OWN_DMA : OWN_CPU;
                wr_d    = grant_dma ? dma_wr : cpu_wr;
                addr_d  = grant_dma ? dma_addr : cpu_addr;
                wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                lat_d   = LW'(MEM_LAT - 1);
                state_d = ACCESS;
            end
            ACCESS: if (lat_q == '0) begin
                cpu_rdata_d = (!wr_q && owner_q == OWN_CPU) ? mem_rdata : cpu_rdata_q;
                dma_rdata_d = (!wr_q && owner_q == OWN_DMA) ? mem_rdata : dma_rdata_q;
                state_d     = DONE;
            end else begin
                lat_d = lat_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            lat_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end
    assign mem_en     = state_q == ACCESS;
    assign mem_wr     = mem_en && wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign cpu_done   = state_q == DONE && owner_q == OWN_CPU;
    assign dma_done   = state_q == DONE && owner_q == OWN_DMA;
    assign pipe_stall = cpu_req && !cpu_done;
endmodule
